spi_cmd_decoder: RTL
====================

# spi_cmd_decoder

Downstream consumer of the SPI receive shift register in the micro-motor controller. Tracks SPI frame boundaries from the raw `ss_n`/`sclk` pads, counts clock edges, and when a frame closes validates and decodes the 32-bit word presented on `spi_data`. It issues register writes to the motor register file over a valid/ready handshake, and keeps motor-enable and status counters.

## Interface
Parameters:
- `SETTLE_CYCLES`, default 2: wait after the frame-end edge before sampling `spi_data`, covering receiver shift latency.
- `ADDR_W`, default 4: register address width.

Ports:
- `clock` in 1: system clock.
- `reset` in 1: asynchronous, active-high reset.
- `ss_n` in 1: raw slave-select pad, active low.
- `sclk` in 1: raw SPI clock pad.
- `spi_data` in 32: shift-register contents from the SPI receiver.
- `wr_valid` out 1: register write request.
- `wr_ready` in 1: register file accepts the write.
- `wr_addr` out ADDR_W: write address.
- `wr_data` out 24: write payload.
- `motor_enable` out 8: latched motor enable mask.
- `frame_count` out 8: count of accepted frames; wraps.
- `err_count` out 8: count of rejected frames; saturates at 255.
- `busy` out 1: high in every state except IDLE.

## Operation
- `ss_n` and `sclk` each pass through 3-flop synchronizers. Edges are taken on bits [2:1]: 01 is rising, 10 is falling.
- Word format:
  - [31] parity (macro only, otherwise ignored)
  - [30:28] cmd
  - [27:24] addr
  - [23:0] data
- FSM states: IDLE, ARMED, SETTLE, DECODE, ISSUE.
  - IDLE: synced `ss_n` falling edge → ARMED. The bit counter clears to 0.
  - ARMED: each synced `sclk` rising edge increments the 6-bit bit counter, saturating at 63. Synced `ss_n` rising edge → SETTLE.
  - SETTLE: count `SETTLE_CYCLES`, then → DECODE.
  - DECODE: single cycle; samples `spi_data` and validates the frame. A frame is rejected if the bit count ≠ 32, cmd is in {4..7}, or (macro) parity fails. On rejection, `err_count`++ and → IDLE.
- Commands in DECODE:
  - cmd 0 NOP: `frame_count`++ → IDLE.
  - cmd 1 WRITE: load `wr_addr`/`wr_data`, `frame_count`++ → ISSUE.
  - cmd 2 ENABLE: `motor_enable` <= data[7:0], `frame_count`++ → IDLE.
  - cmd 3 DISABLE: `motor_enable` <= 0, `frame_count`++ → IDLE.
- ISSUE: `wr_valid` held high, with `wr_addr`/`wr_data` stable, until `wr_valid & wr_ready` is sampled. Then `wr_valid` drops on the next edge → IDLE.
- Overrun: a synced `ss_n` falling edge while in ISSUE → `err_count`++ and that frame is ignored. The FSM stays in ISSUE; the pending write is not disturbed. The ignored frame is not tracked.
- Reset values: all outputs 0; FSM IDLE; bit counter 0; synchronizers 3'b111 for `ss_n`, 3'b000 for `sclk`. Reset asserted mid-frame or mid-ISSUE aborts immediately; the next frame must begin with a fresh `ss_n` fall.

## Timing
- Synced `ss_n` rise detected at cycle k: SETTLE spans k+1..k+`SETTLE_CYCLES`. DECODE is at k+`SETTLE_CYCLES`+1. `wr_valid` is first high at k+`SETTLE_CYCLES`+2.
- Pad-to-detect latency is 3 clocks for both `ss_n` and `sclk`.
- `wr_ready` may already be high when `wr_valid` rises: the write completes in one cycle and `wr_valid` is high for exactly one cycle.
- Back-to-back writes: minimum gap between successive `wr_valid` pulses is one frame, i.e. no combinational path from `wr_ready` to the next request.
- `frame_count` and `err_count` update in the DECODE cycle. Overrun errors update in the cycle the fall is detected.
- `err_count` holds at 255. `frame_count` wraps 255→0.

## Configuration
- `SPI_CMD_PARITY_EN` defined: bit 31 must make the popcount of [31:0] even, otherwise the frame is rejected in DECODE.
- Not defined: bit 31 ignored; no parity logic.

## Structure
- Shared package `spi_cmd_pkg`: cmd encodings (CMD_NOP=0, CMD_WRITE=1, CMD_ENABLE=2, CMD_DISABLE=3), FSM state enum, frame length constant 32, word field bit positions.
- One sub-module: `sync_edge_det`, a 3-flop synchronizer with rise/fall outputs and a reset-value parameter. It is instantiated for `ss_n` and for `sclk`.

## Test plan
- WRITE frame 0x1A00_1234, 32 sclk pulses, `wr_ready`=1 → one `wr_valid` pulse, `wr_addr`=0xA, `wr_data`=0x001234, `frame_count`=1.
- ENABLE frame 0x2000_00A5 then DISABLE frame 0x3000_0000 → `motor_enable` reads 0xA5, then 0x00; `err_count`=0.
- 31-sclk frame and cmd-7 frame → no write, `err_count`=2, `motor_enable` unchanged.
- WRITE with `wr_ready`=0 held 20 cycles, a second frame started meanwhile → `wr_valid` stable 20+ cycles, `err_count`=1, exactly one write completes when `wr_ready` rises.
- `reset` pulsed while in ARMED at bit 16 → all outputs 0. The following full frame 0x1100_0001 decodes normally.
- With `SPI_CMD_PARITY_EN`: 0x9100_0000 (odd popcount) → rejected, `err_count`=1. 0x1100_0000 → accepted.

Source files
------------

// File: rtl/spi_cmd_pkg.sv
// Shared definitions for the SPI command decoder: command codes, FSM states,
// frame length and word field positions.
package spi_cmd_pkg;

  localparam int FRAME_BITS = 32;

  localparam int PAR_BIT  = 31;
  localparam int CMD_MSB  = 30;
  localparam int CMD_LSB  = 28;
  localparam int ADDR_MSB = 27;
  localparam int ADDR_LSB = 24;
  localparam int DATA_MSB = 23;
  localparam int DATA_LSB = 0;

  localparam logic [2:0] CMD_NOP     = 3'd0;
  localparam logic [2:0] CMD_WRITE   = 3'd1;
  localparam logic [2:0] CMD_ENABLE  = 3'd2;
  localparam logic [2:0] CMD_DISABLE = 3'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARMED,
    ST_SETTLE,
    ST_DECODE,
    ST_ISSUE
  } state_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] val);
    return (val == 8'hFF) ? val : val + 8'd1;
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Three-flop pad synchronizer with rise/fall strobes taken from the two
// oldest stages; RST_VAL sets the idle level the chain resets to.
module sync_edge_det #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic pad,
  output logic rise,
  output logic fall
);

  logic [2:0] sync;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) sync <= {3{RST_VAL}};
    else       sync <= {sync[1:0], pad};
  end

  assign rise = (sync[2:1] == 2'b01);
  assign fall = (sync[2:1] == 2'b10);

endmodule

// File: rtl/spi_cmd_decoder.sv
// SPI frame tracker and command decoder feeding the motor register file.
// Optional even-parity check over the whole word: define SPI_CMD_PARITY_EN.
//
// state  | meaning
// IDLE   | waiting for ss_n to fall
// ARMED  | frame open, counting sclk rising edges
// SETTLE | frame closed, waiting for receiver shift latency
// DECODE | sample spi_data, validate, execute command
// ISSUE  | holding a register write until wr_ready
module spi_cmd_decoder
  import spi_cmd_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int ADDR_W        = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ss_n,
  input  logic              sclk,
  input  logic [31:0]       spi_data,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [23:0]       wr_data,
  output logic [7:0]        motor_enable,
  output logic [7:0]        frame_count,
  output logic [7:0]        err_count,
  output logic              busy
);

  localparam int SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE_CYCLES - 1);

  state_t              state;
  logic [5:0]          bit_cnt;
  logic [SETTLE_W-1:0] settle_cnt;

  logic ss_rise, ss_fall, sclk_rise, sclk_fall_unused;
  logic [2:0] cmd;
  logic parity_bad, frame_bad;

  sync_edge_det #(.RST_VAL(1'b1)) u_ss_sync (
    .clock (clock),
    .reset (reset),
    .pad   (ss_n),
    .rise  (ss_rise),
    .fall  (ss_fall)
  );

  sync_edge_det #(.RST_VAL(1'b0)) u_sclk_sync (
    .clock (clock),
    .reset (reset),
    .pad   (sclk),
    .rise  (sclk_rise),
    .fall  (sclk_fall_unused)
  );

  assign cmd = spi_data[CMD_MSB:CMD_LSB];

`ifdef SPI_CMD_PARITY_EN
  assign parity_bad = ^spi_data;
`else
  logic par_bit_unused;
  assign par_bit_unused = spi_data[PAR_BIT];
  assign parity_bad     = 1'b0;
`endif

  // Codes 4..7 are reserved and share the reject path with bad lengths.
  assign frame_bad = (bit_cnt != 6'(FRAME_BITS)) || cmd[2] || parity_bad;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      bit_cnt      <= '0;
      settle_cnt   <= '0;
      wr_valid     <= 1'b0;
      wr_addr      <= '0;
      wr_data      <= '0;
      motor_enable <= '0;
      frame_count  <= '0;
      err_count    <= '0;
      busy         <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (ss_fall) begin
            state   <= ST_ARMED;
            bit_cnt <= '0;
            busy    <= 1'b1;
          end
        end

        ST_ARMED: begin
          if (sclk_rise && bit_cnt != 6'd63) bit_cnt <= bit_cnt + 6'd1;
          if (ss_rise) begin
            state      <= ST_SETTLE;
            settle_cnt <= SETTLE_LOAD;
          end
        end

        ST_SETTLE: begin
          if (settle_cnt == '0) state <= ST_DECODE;
          else                  settle_cnt <= settle_cnt - 1'b1;
        end

        ST_DECODE: begin
          if (frame_bad) begin
            err_count <= sat_inc8(err_count);
            state     <= ST_IDLE;
            busy      <= 1'b0;
          end else begin
            frame_count <= frame_count + 8'd1;
            case (cmd)
              CMD_WRITE: begin
                wr_addr  <= ADDR_W'(spi_data[ADDR_MSB:ADDR_LSB]);
                wr_data  <= spi_data[DATA_MSB:DATA_LSB];
                wr_valid <= 1'b1;
                state    <= ST_ISSUE;
              end
              CMD_ENABLE: begin
                motor_enable <= spi_data[7:0];
                state        <= ST_IDLE;
                busy         <= 1'b0;
              end
              CMD_DISABLE: begin
                motor_enable <= '0;
                state        <= ST_IDLE;
                busy         <= 1'b0;
              end
              default: begin
                state <= ST_IDLE;
                busy  <= 1'b0;
              end
            endcase
          end
        end

        ST_ISSUE: begin
          // A new frame opening here is an overrun; it is counted and dropped.
          if (ss_fall) err_count <= sat_inc8(err_count);
          if (wr_valid && wr_ready) begin
            wr_valid <= 1'b0;
            state    <= ST_IDLE;
            busy     <= 1'b0;
          end
        end

        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
